// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, requester ids and line geometry.
// Optional round-robin arbitration is enabled by defining CACHELINE_ARB_RR_EN.
package cacheline_arb_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } req_src_t;

endpackage

// File: rtl/cacheline_arbiter_select.sv
// Combinational grant pick between I-cache and D-cache requests.
// CACHELINE_ARB_RR_EN selects round-robin on collisions; otherwise D-cache always wins.
module cacheline_arb_select
  import cacheline_arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  req_src_t last_grant,
  output logic     grant_valid,
  output req_src_t grant_src
);

`ifndef CACHELINE_ARB_RR_EN
  // Kept on the port so both builds share one interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_valid = i_req | d_req;
    grant_src   = SRC_D;
    if (i_req && d_req) begin
`ifdef CACHELINE_ARB_RR_EN
      grant_src = (last_grant == SRC_D) ? SRC_I : SRC_D;
`else
      grant_src = SRC_D;
`endif
    end else if (i_req) begin
      grant_src = SRC_I;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline adaptor port between the I-cache and D-cache, one transaction at a time.
// Valid/ready: a cache holds its request until its resp pulse; the grant is held until mem_resp.
// Arbitration mode is set by CACHELINE_ARB_RR_EN (round-robin) or its absence (fixed D priority).
module cacheline_arbiter
  import cacheline_arb_types::*;
#(
  parameter int LINE_W_P = LINE_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W_P-1:0] i_address,
  output logic [LINE_W_P-1:0] i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W_P-1:0] d_address,
  input  logic [LINE_W_P-1:0] d_wdata,
  output logic [LINE_W_P-1:0] d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W_P-1:0] mem_address,
  output logic [LINE_W_P-1:0] mem_wdata,
  input  logic [LINE_W_P-1:0] mem_rdata,
  input  logic                mem_resp,
  output arb_state_t          dbg_state
);

  arb_state_t state_q, state_d;
  req_src_t   last_grant_q, last_grant_d;
  logic       grant_valid;
  req_src_t   grant_src;

  cacheline_arb_select u_select (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = (grant_src == SRC_D) ? SERVE_D : SERVE_I;
          last_grant_d = grant_src;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are forced low while rst is high so an aborted transaction drops immediately.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    if (!rst) begin
      case (state_q)
        SERVE_I: begin
          mem_read    = 1'b1;
          mem_address = i_address;
          i_resp      = mem_resp;
        end
        SERVE_D: begin
          mem_write   = d_write;
          mem_read    = d_read & ~d_write;
          mem_address = d_address;
          mem_wdata   = d_wdata;
          d_resp      = mem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign dbg_state = state_q;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write));

  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_I) |-> i_read);

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_D) |-> (d_read || d_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed cases plus randomized transactions against a grant-order model.
module tb_cacheline_arbiter;
  import cacheline_arb_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  arb_state_t    dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [LW-1:0] exp_q[$];
  bit model_last_d;

  cacheline_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state_idle(input string tag);
    n_assert++;
    assert (dbg_state === IDLE) else begin
      n_fail++;
      $error("FAIL %s: observed state %0d expected %0d", tag, dbg_state, IDLE);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, ".mem_read"}, mem_read, 1'b0);
    chk1({tag, ".mem_write"}, mem_write, 1'b0);
    chkw({tag, ".mem_address"}, {{(LW-AW){1'b0}}, mem_address}, '0);
    chkw({tag, ".mem_wdata"}, mem_wdata, '0);
    chk1({tag, ".i_resp"}, i_resp, 1'b0);
    chk1({tag, ".d_resp"}, d_resp, 1'b0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Who wins when the requesters in ir/dr are waiting in IDLE.
  function automatic bit pick_d(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef CACHELINE_ARB_RR_EN
      return !model_last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // Plays the adaptor for one granted transaction; entered at the first granted cycle.
  task automatic serve(input bit is_d, input logic [AW-1:0] addr, input bit wr,
                       input logic [LW-1:0] wdata, input int lat,
                       input logic [LW-1:0] rdata, input string tag);
    logic [LW-1:0] noise, exp_data;
    exp_q.push_back(rdata);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      if (k == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_resp  = 1'b0;
        noise     = rand_line();
        mem_rdata = noise;
      end
      #1;
      chk1({tag, ".mem_read"}, mem_read, is_d ? ~wr : 1'b1);
      chk1({tag, ".mem_write"}, mem_write, is_d & wr);
      chkw({tag, ".mem_address"}, {{(LW-AW){1'b0}}, mem_address}, {{(LW-AW){1'b0}}, addr});
      chkw({tag, ".mem_wdata"}, mem_wdata, is_d ? wdata : '0);
      chk1({tag, ".i_resp"}, i_resp, !is_d && (k == lat));
      chk1({tag, ".d_resp"}, d_resp, is_d && (k == lat));
      if (k == lat) begin
        exp_data = exp_q.pop_front();
        chkw({tag, ".rdata"}, is_d ? d_rdata : i_rdata, exp_data);
      end else begin
        chkw({tag, ".rdata_pass"}, is_d ? d_rdata : i_rdata, noise);
      end
    end
  endtask

  task automatic drop(input bit is_d);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    mem_resp = 1'b0;
  endtask

  // One round: raise the chosen requests together, serve them in model order.
  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input logic [AW-1:0] ia, input logic [AW-1:0] da,
                     input logic [LW-1:0] wd, input logic [LW-1:0] idata,
                     input logic [LW-1:0] ddata, input int li, input int ld,
                     input string tag);
    bit first_d;
    @(negedge clk);
    i_read    = ir;
    i_address = ia;
    d_read    = dr & ~dw;
    d_write   = dr & dw;
    d_address = da;
    d_wdata   = wd;
    mem_resp  = 1'b0;
    #1;
    chk_idle({tag, ".req"});
    first_d      = pick_d(ir, dr);
    model_last_d = first_d;
    @(negedge clk);
    if (first_d) serve(1'b1, da, dw, wd, ld, ddata, {tag, ".first_d"});
    else         serve(1'b0, ia, 1'b0, '0, li, idata, {tag, ".first_i"});
    @(negedge clk);
    drop(first_d);
    #1;
    chk_idle({tag, ".bubble"});
    chk_state_idle({tag, ".bubble_state"});
    if (ir && dr) begin
      model_last_d = !first_d;
      @(negedge clk);
      if (!first_d) serve(1'b1, da, dw, wd, ld, ddata, {tag, ".second_d"});
      else          serve(1'b0, ia, 1'b0, '0, li, idata, {tag, ".second_i"});
      @(negedge clk);
      drop(!first_d);
      #1;
      chk_idle({tag, ".end"});
      chk_state_idle({tag, ".end_state"});
    end
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    model_last_d = 1'b1;

    // Reset cycle and the cycle after
    @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("post_reset");
    chk_state_idle("post_reset_state");

    // I-only read
    txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, '0, '0, {32{8'hA5}}, '0, 4, 0, "i_only");

    // D write-back
    txn(1'b0, 1'b1, 1'b1, '0, 32'h0000_1000, {8{32'h1234_5678}}, '0, rand_line(), 0, 3,
        "d_write");

    // Collisions, three rounds
    for (int r = 0; r < 3; r++)
      txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), rand_line(), rand_line(),
          $urandom_range(1, 3), $urandom_range(1, 3), $sformatf("collide%0d", r));

    // Reset two cycles after mem_read rises
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h0000_0080;
    #1;
    chk_idle("rst_mid.req");
    @(negedge clk);
    #1;
    chk1("rst_mid.rise", mem_read, 1'b1);
    @(negedge clk);
    #1;
    chk1("rst_mid.hold", mem_read, 1'b1);
    chk1("rst_mid.hold_resp", i_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1; i_read = 1'b0; mem_rdata = '0;
    #1;
    chk_idle("rst_mid.rst_cycle");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("rst_mid.after");
    chk_state_idle("rst_mid.after_state");
    model_last_d = 1'b1;
    txn(1'b1, 1'b0, 1'b0, 32'h0000_0080, '0, '0, rand_line(), '0, 2, 0, "rst_mid.fresh");

    // Spurious mem_resp in IDLE
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = rand_line();
    #1;
    chk1("spurious.i_resp", i_resp, 1'b0);
    chk1("spurious.d_resp", d_resp, 1'b0);
    chk1("spurious.mem_read", mem_read, 1'b0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk_idle("spurious.after");
    chk_state_idle("spurious.after_state");

    // Randomized rounds
    for (int n = 0; n < 16; n++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, rand_line(), rand_line(),
          rand_line(), $urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
